// File: rtl/writeback_regfile_pkg.sv
// Shared CPU package: datapath width default, register address width,
// the x0 address constant and a helper that decides whether a register
// address names real, writable storage.
package writeback_regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_N_DEF  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int COUNT_W    = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t X0_ADDR = '0;

  // True when addr refers to a storage register: not x0 and below reg_n.
  // Addresses at or above reg_n only exist when reg_n < 32 and behave like x0.
  function automatic logic addr_writable(input reg_addr_t addr, input int unsigned reg_n);
    return (addr != X0_ADDR) && (32'(addr) < reg_n);
  endfunction

endpackage

// File: rtl/writeback_regfile_if.sv
// MEM/WB writeback and ID-stage read bus of the register file.
// Write qualifier: a write is offered whenever RegWrite_i is high during a
// cycle; there is no ready/back-pressure, the register file accepts it on the
// next rising clock edge unless reset is low or the target is x0/out of range.
interface writeback_regfile_if
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              RegWrite_i;
  logic              MemtoReg_i;
  logic [DATA_W-1:0] ALUResult_i;
  logic [DATA_W-1:0] Memdata_i;
  reg_addr_t         RDaddr_i;
  reg_addr_t         RS1addr_i;
  reg_addr_t         RS2addr_i;
  logic [DATA_W-1:0] RS1data_o;
  logic [DATA_W-1:0] RS2data_o;
  logic [DATA_W-1:0] WBdata_o;
  logic [COUNT_W-1:0] WBcount_o;

  // Pipeline side: drives writeback and read addresses, consumes read data.
  modport master (
    output RegWrite_i, MemtoReg_i, ALUResult_i, Memdata_i,
    output RDaddr_i, RS1addr_i, RS2addr_i,
    input  RS1data_o, RS2data_o, WBdata_o, WBcount_o
  );

  // Register file side.
  modport slave (
    input  RegWrite_i, MemtoReg_i, ALUResult_i, Memdata_i,
    input  RDaddr_i, RS1addr_i, RS2addr_i,
    output RS1data_o, RS2data_o, WBdata_o, WBcount_o
  );

endinterface

// File: rtl/writeback_regfile_wb_mux.sv
// Writeback source select: load data or ALU result, purely combinational so
// the chosen value is available to EX-stage forwarding in the same cycle.
module wb_mux
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              sel_mem,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] wb_data
);

  // 2:1 select, no register stage.
  always_comb begin
    wb_data = sel_mem ? mem_data : alu_result;
  end

endmodule

// File: rtl/writeback_regfile.sv
// Architectural register file with writeback mux, write-before-read bypass
// on both read ports and a count of committed writes.
// x0 and any address >= REG_N read as zero and silently drop writes.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_N  = REG_N_DEF
) (
  input logic                clk_i,
  input logic                rst_i,
  writeback_regfile_if.slave bus
);

  logic [DATA_W-1:0]  regs_q [1:REG_N-1];
  logic [COUNT_W-1:0] wb_count_q;
  logic [DATA_W-1:0]  wb_data;
  logic [DATA_W-1:0]  rs1_data;
  logic [DATA_W-1:0]  rs2_data;
  logic               commit;

  wb_mux #(
    .DATA_W (DATA_W)
  ) u_wb_mux (
    .sel_mem    (bus.MemtoReg_i),
    .alu_result (bus.ALUResult_i),
    .mem_data   (bus.Memdata_i),
    .wb_data    (wb_data)
  );

  // A write commits only out of reset, when enabled, to a real register.
  always_comb begin
    commit = rst_i && bus.RegWrite_i && addr_writable(bus.RDaddr_i, REG_N);
  end

  // Register storage; reset clears everything asynchronously and wins over
  // a write presented on the same edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 1; i < REG_N; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[bus.RDaddr_i] <= wb_data;
    end
  end

  // Committed-write counter, wraps naturally at 2^COUNT_W.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb_count_q <= '0;
    end else if (commit) begin
      wb_count_q <= wb_count_q + COUNT_W'(1);
    end
  end

  // Read ports with independent bypass of the in-flight writeback value;
  // during reset both ports read zero and nothing is bypassed.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rst_i) begin
      if (addr_writable(bus.RS1addr_i, REG_N)) begin
        rs1_data = (commit && (bus.RS1addr_i == bus.RDaddr_i)) ? wb_data
                                                               : regs_q[bus.RS1addr_i];
      end
      if (addr_writable(bus.RS2addr_i, REG_N)) begin
        rs2_data = (commit && (bus.RS2addr_i == bus.RDaddr_i)) ? wb_data
                                                               : regs_q[bus.RS2addr_i];
      end
    end
  end

  assign bus.RS1data_o = rs1_data;
  assign bus.RS2data_o = rs2_data;
  assign bus.WBdata_o  = wb_data;
  assign bus.WBcount_o = wb_count_q;

endmodule
